// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Holds the FSM state enum, datapath widths and the per-slot digit enable patterns.
package seg_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int BCD_W      = 16;
   localparam int VAL_W      = 14;
   localparam logic [VAL_W-1:0] MAX_VAL = 14'd9999;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT
   } state_t;

   localparam logic [NUM_DIGITS-1:0] EN_SLOT0 = 4'b0111;
   localparam logic [NUM_DIGITS-1:0] EN_SLOT1 = 4'b1011;
   localparam logic [NUM_DIGITS-1:0] EN_SLOT2 = 4'b1101;
   localparam logic [NUM_DIGITS-1:0] EN_SLOT3 = 4'b1110;
   localparam logic [NUM_DIGITS-1:0] EN_DARK  = 4'b1111;

   function automatic logic [NUM_DIGITS-1:0] slot_enable(input logic [1:0] slot);
      case (slot)
         2'd0:    return EN_SLOT0;
         2'd1:    return EN_SLOT1;
         2'd2:    return EN_SLOT2;
         default: return EN_SLOT3;
      endcase
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Producer, converter and display signals of seg_scan_ctrl bundled as one interface.
// The slave modport is the controller's view; master is the surrounding logic.
interface seg_scan_ctrl_if;
   import seg_pkg::*;

   logic [VAL_W-1:0]      value_i;
   logic                  value_valid_i;
   logic                  value_ready_o;
   logic                  conv_start_o;
   logic [VAL_W-1:0]      conv_value_o;
   logic [BCD_W-1:0]      conv_bcd_i;
   logic                  conv_dv_i;
   logic [3:0]            digit_o;
   logic [NUM_DIGITS-1:0] digit_enable_n_o;
   logic                  overflow_o;
   logic                  conv_error_o;

   modport slave (
      input  value_i, value_valid_i, conv_bcd_i, conv_dv_i,
      output value_ready_o, conv_start_o, conv_value_o,
             digit_o, digit_enable_n_o, overflow_o, conv_error_o
   );

   modport master (
      output value_i, value_valid_i, conv_bcd_i, conv_dv_i,
      input  value_ready_o, conv_start_o, conv_value_o,
             digit_o, digit_enable_n_o, overflow_o, conv_error_o
   );

endinterface

// File: rtl/seg_scan_ctrl_scan_timer.sv
// Digit scan timebase: prescaler producing a one-cycle tick every SCAN_DIV cycles
// and a 2-bit slot index that advances on each tick.
module scan_timer #(
   parameter int SCAN_DIV = 16000
) (
   input  logic       CLK,
   input  logic       RST_N,
   output logic       o_tick,
   output logic [1:0] o_slot
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

   logic [PW-1:0] r_presc;
   logic [1:0]    r_slot;

   assign o_tick = (r_presc == LAST);
   assign o_slot = r_slot;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_presc <= '0;
         r_slot  <= '0;
      end else if (o_tick) begin
         r_presc <= '0;
         r_slot  <= r_slot + 2'd1;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Sequencing controller: accepts a binary value, runs one BCD conversion, scans 4 digits.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int SCAN_DIV     = 16000,
   parameter int CONV_TIMEOUT = 64
) (
   input  logic            CLK,
   input  logic            RST_N,
   seg_scan_ctrl_if.slave  bus
);

   localparam int TW = $clog2(CONV_TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(CONV_TIMEOUT - 1);

   state_t                r_state;
   logic                  r_ready;
   logic                  r_start;
   logic [VAL_W-1:0]      r_conv_value;
   logic                  r_ovf;
   logic                  r_err;
   logic [TW-1:0]         r_tmo;
   logic [BCD_W-1:0]      r_disp;
   logic [3:0]            r_digit;
   logic [NUM_DIGITS-1:0] r_en_n;

   logic                  w_tick;
   logic [1:0]            w_slot;
   logic [3:0]            w_nibble;
   logic                  w_blank;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state      <= ST_IDLE;
         r_ready      <= 1'b1;
         r_start      <= 1'b0;
         r_conv_value <= '0;
         r_ovf        <= 1'b0;
         r_err        <= 1'b0;
         r_tmo        <= '0;
         r_disp       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.value_valid_i && r_ready) begin
                  r_conv_value <= (bus.value_i > MAX_VAL) ? MAX_VAL : bus.value_i;
                  r_ovf        <= (bus.value_i > MAX_VAL);
                  r_err        <= 1'b0;
                  r_ready      <= 1'b0;
                  r_start      <= 1'b1;
                  r_state      <= ST_START;
               end
            end
            ST_START: begin
               r_start <= 1'b0;
               r_tmo   <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // A result arriving on the terminal timeout cycle still wins.
               if (bus.conv_dv_i) begin
                  r_disp  <= bus.conv_bcd_i;
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (r_tmo == TMO_LAST) begin
                  r_err   <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            default: begin
               r_start <= 1'b0;
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan_timer (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .o_tick (w_tick),
      .o_slot (w_slot)
   );

   assign w_nibble = r_disp[{w_slot, 2'b00} +: 4];

`ifdef SEG_LZ_BLANK_EN
   // Upper slots go dark while their nibble and everything above it is zero.
   assign w_blank = (w_slot != 2'd0) && ((r_disp >> {w_slot, 2'b00}) == '0);
`else
   assign w_blank = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_digit <= '0;
         r_en_n  <= EN_DARK;
      end else if (w_tick) begin
         r_digit <= w_nibble;
         r_en_n  <= w_blank ? EN_DARK : slot_enable(w_slot);
      end
   end

   assign bus.value_ready_o    = r_ready;
   assign bus.conv_start_o     = r_start;
   assign bus.conv_value_o     = r_conv_value;
   assign bus.overflow_o       = r_ovf;
   assign bus.conv_error_o     = r_err;
   assign bus.digit_o          = r_digit;
   assign bus.digit_enable_n_o = r_en_n;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seg_scan_ctrl;
   import seg_pkg::*;

   localparam int SD = 8;
   localparam int CT = 32;
   localparam logic [3:0] PAT [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
`ifdef SEG_LZ_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   seg_scan_ctrl_if bus();

   seg_scan_ctrl #(.SCAN_DIV(SD), .CONV_TIMEOUT(CT)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // Reference model state: edge count since reset release and transaction timestamps.
   int          e;
   bit          m_busy, m_acc;
   int          m_a, m_sched;
   logic [13:0] m_cv;
   bit          m_ovf, m_err;
   logic [15:0] m_disp;
   logic [3:0]  m_dig, m_en;

   int lat_cfg = 5;
   int spur_pct = 0;
   bit rnd_prod = 1'b0;

   logic [3:0] cap_dig [4];
   bit         cap_seen [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic m_reset();
      e = 0; m_busy = 0; m_acc = 0; m_a = -100; m_sched = -1;
      m_cv = '0; m_ovf = 0; m_err = 0; m_disp = '0; m_dig = '0; m_en = 4'hF;
   endtask

   task automatic model_edge();
      int slot;
      int v;
      e++;
      m_acc = 0;
      if (e % SD == 0) begin
         slot  = ((e / SD) - 1) % 4;
         m_dig = m_disp[4*slot +: 4];
         m_en  = PAT[slot];
         if (BLANK && slot != 0 && (m_disp >> (4*slot)) == 16'h0) m_en = 4'hF;
      end
      if (!m_busy) begin
         if (bus.value_valid_i === 1'b1) begin
            v       = int'(bus.value_i);
            m_busy  = 1; m_acc = 1; m_a = e;
            m_cv    = (v > 9999) ? 14'd9999 : 14'(v);
            m_ovf   = (v > 9999);
            m_err   = 0;
            m_sched = e + 1 + ((lat_cfg < 0) ? int'($urandom_range(1, CT + 3)) : lat_cfg);
         end
      end else if (e >= m_a + 2 && bus.conv_dv_i === 1'b1) begin
         m_disp = bus.conv_bcd_i;
         m_busy = 0;
      end else if (e == m_a + 1 + CT) begin
         m_err  = 1;
         m_busy = 0;
      end
   endtask

   task automatic compare();
      chk("ready",      32'(bus.value_ready_o),    32'(!m_busy));
      chk("start",      32'(bus.conv_start_o),     32'(m_busy && e == m_a));
      chk("conv_value", 32'(bus.conv_value_o),     32'(m_cv));
      chk("overflow",   32'(bus.overflow_o),       32'(m_ovf));
      chk("conv_error", 32'(bus.conv_error_o),     32'(m_err));
      chk("digit",      32'(bus.digit_o),          32'(m_dig));
      chk("enable_n",   32'(bus.digit_enable_n_o), 32'(m_en));
   endtask

   task automatic drive();
      if (m_acc) bus.value_valid_i = 1'b0;
      if (rnd_prod) begin
         bus.value_valid_i = ($urandom_range(0, 2) == 0);
         bus.value_i = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(10000, 16383))
                                                   : 14'($urandom_range(0, 9999));
      end
      if (m_busy && m_sched == e + 1) begin
         bus.conv_dv_i  = 1'b1;
         bus.conv_bcd_i = to_bcd(int'(m_cv));
      end else begin
         bus.conv_dv_i  = (int'($urandom_range(0, 99)) < spur_pct);
         bus.conv_bcd_i = 16'($urandom);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      compare();
      drive();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && m_busy; i++) step();
   endtask

   task automatic offer(input int v, input int lat);
      lat_cfg = lat;
      bus.value_i = 14'(v);
      bus.value_valid_i = 1'b1;
      step();
   endtask

   // Run one frame so the latest display is visible, then record each lit slot over a frame.
   task automatic capture();
      repeat (4*SD) step();
      for (int k = 0; k < 4; k++) begin cap_seen[k] = 0; cap_dig[k] = 4'hX; end
      repeat (4*SD) begin
         step();
         for (int k = 0; k < 4; k++)
            if (bus.digit_enable_n_o == PAT[k]) begin cap_seen[k] = 1; cap_dig[k] = bus.digit_o; end
      end
   endtask

   initial begin
      bus.value_i = '0; bus.value_valid_i = 1'b0; bus.conv_bcd_i = '0; bus.conv_dv_i = 1'b0;
      m_reset();
      repeat (3) @(negedge CLK);
      chk("rst_ready",  32'(bus.value_ready_o),    32'd1);
      chk("rst_start",  32'(bus.conv_start_o),     32'd0);
      chk("rst_cv",     32'(bus.conv_value_o),     32'd0);
      chk("rst_enable", 32'(bus.digit_enable_n_o), 32'hF);
      RST_N = 1'b1;

      // Dark until the first tick exactly SD cycles after release, then slot 0.
      repeat (SD-1) step();
      chk("pre_tick_enable", 32'(bus.digit_enable_n_o), 32'hF);
      step();
      chk("first_tick_enable", 32'(bus.digit_enable_n_o), 32'h7);
      chk("first_tick_digit",  32'(bus.digit_o),          32'd0);
      repeat (2*SD) step();

      offer(1234, 20);
      chk("cv_1234",    32'(bus.conv_value_o), 32'd1234);
      chk("start_1234", 32'(bus.conv_start_o), 32'd1);
      wait_idle();
      capture();
      chk("slot0_1234", 32'(cap_dig[0]), 32'd4);
      chk("slot1_1234", 32'(cap_dig[1]), 32'd3);
      chk("slot2_1234", 32'(cap_dig[2]), 32'd2);
      chk("slot3_1234", 32'(cap_dig[3]), 32'd1);

      offer(12000, 5);
      chk("cv_clamp", 32'(bus.conv_value_o), 32'd9999);
      chk("ovf_set",  32'(bus.overflow_o),   32'd1);
      wait_idle();
      offer(5, 5);
      chk("ovf_clear", 32'(bus.overflow_o),   32'd0);
      chk("cv_5",      32'(bus.conv_value_o), 32'd5);
      wait_idle();

      offer(777, 1000);
      chk("start_tmo", 32'(bus.conv_start_o), 32'd1);
      repeat (CT) step();
      chk("err_before_tmo", 32'(bus.conv_error_o), 32'd0);
      step();
      chk("err_at_tmo",   32'(bus.conv_error_o),  32'd1);
      chk("ready_at_tmo", 32'(bus.value_ready_o), 32'd1);
      capture();
      chk("slot0_kept", 32'(cap_dig[0]), 32'd5);

      offer(321, CT);
      wait_idle();
      chk("err_collision", 32'(bus.conv_error_o), 32'd0);
      capture();
      chk("slot0_321", 32'(cap_dig[0]), 32'd1);
      chk("slot2_321", 32'(cap_dig[2]), 32'd3);

      bus.conv_dv_i = 1'b1; bus.conv_bcd_i = 16'h8888;
      step();
      capture();
      chk("slot0_spurious", 32'(cap_dig[0]), 32'd1);

      offer(42, 3);
      wait_idle();
      capture();
      chk("slot1_42", 32'(cap_dig[1]), 32'd4);
      chk("slot0_42", 32'(cap_dig[0]), 32'd2);
`ifdef SEG_LZ_BLANK_EN
      chk("slot3_42_dark", 32'(cap_seen[3]), 32'd0);
      chk("slot2_42_dark", 32'(cap_seen[2]), 32'd0);
`else
      chk("slot3_42_lit", 32'(cap_seen[3]), 32'd1);
      chk("slot3_42_dig", 32'(cap_dig[3]),  32'd0);
`endif
      offer(0, 3);
      wait_idle();
      capture();
      chk("slot0_0_lit", 32'(cap_seen[0]), 32'd1);
      chk("slot0_0_dig", 32'(cap_dig[0]),  32'd0);
`ifdef SEG_LZ_BLANK_EN
      chk("slot1_0_dark", 32'(cap_seen[1]), 32'd0);
`else
      chk("slot1_0_lit", 32'(cap_seen[1]), 32'd1);
`endif

      // Load a non-zero display, then reset mid-conversion and feed a late result.
      offer(9876, 4);
      wait_idle();
      offer(1111, 1000);
      step(); step();
      #2 RST_N = 1'b0;
      #1;
      chk("midrst_ready", 32'(bus.value_ready_o),    32'd1);
      chk("midrst_start", 32'(bus.conv_start_o),     32'd0);
      chk("midrst_cv",    32'(bus.conv_value_o),     32'd0);
      chk("midrst_en",    32'(bus.digit_enable_n_o), 32'hF);
      m_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      bus.conv_dv_i = 1'b1; bus.conv_bcd_i = 16'h4321;
      step();
      capture();
      chk("late_dv_slot0", 32'(cap_dig[0]), 32'd0);

      rnd_prod = 1'b1; lat_cfg = -1; spur_pct = 3;
      repeat (3000) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Sequencing controller for the 4-digit multiplexed seven-segment display path. It accepts binary values from a producer over a valid/ready handshake. For each value it runs one binary-to-BCD conversion on the shared double-dabble converter, latches the BCD result into a display register, and scans the four digits round-robin into the `SevSeg` decoder and the active-low digit enables. It sits between the application counter logic and `SevSeg`/`DoubleDabble` in `top`.

## Interface
- `SCAN_DIV`, 16000: CLK cycles per digit slot (1 ms at 16 MHz); legal 2..2^20.
- `CONV_TIMEOUT`, 64: maximum CLK cycles waited for `conv_dv_i` after a start; legal 8..1023.

- `CLK` in 1: 16 MHz system clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `value_i` in 14: binary value to display.
- `value_valid_i` in 1: producer has a value.
- `value_ready_o` out 1: controller can accept a value.
- `conv_start_o` out 1: one-cycle start pulse to the converter.
- `conv_value_o` out 14: converter operand, held stable from start until done.
- `conv_bcd_i` in 16: converter result; four BCD nibbles, nibble 0 is the units digit.
- `conv_dv_i` in 1: converter result valid, single cycle.
- `digit_o` out 4: BCD nibble to `SevSeg`.
- `digit_enable_n_o` out 4: active-low digit enables.
- `overflow_o` out 1: last accepted value exceeded 9999 and was clamped.
- `conv_error_o` out 1: last conversion timed out.

## Operation
- FSM states: IDLE, START, WAIT.
- IDLE:
  - `value_ready_o`=1.
  - On `value_valid_i`&`value_ready_o`, capture `min(value_i,9999)` into `conv_value_o`.
  - Set `overflow_o` = (`value_i`>9999) and clear `conv_error_o`.
  - Go to START.
- START: `conv_start_o`=1 for exactly this cycle; go to WAIT. Clear the timeout counter.
- WAIT:
  - On `conv_dv_i`: latch `conv_bcd_i` into the display register and go to IDLE.
  - Otherwise, when the timeout counter reaches `CONV_TIMEOUT`-1: set `conv_error_o`, keep the old display register, and go to IDLE.
- `conv_dv_i` is ignored in IDLE and START. `value_ready_o`=0 outside IDLE.
- Scanner:
  - A prescaler counts 0..`SCAN_DIV`-1 and produces a one-cycle tick at the terminal count.
  - Each tick registers the slot given by the slot index, then advances the index 0→1→2→3→0.
  - Slot k drives `digit_o` = display[4k+3:4k].
  - Slot enables: slot 0 → `digit_enable_n_o` = 4'b0111; slot 1 → 4'b1011; slot 2 → 4'b1101; slot 3 → 4'b1110.
- Scanner and FSM are independent. A display register update affects outputs only from the next tick. The scan never stalls.

## Timing
- Reset values:
  - FSM = IDLE, `value_ready_o`=1, `conv_start_o`=0, `conv_value_o`=0.
  - Display register = 0, `digit_o`=0, `digit_enable_n_o`=4'b1111 (all dark), `overflow_o`=0, `conv_error_o`=0.
  - Prescaler and slot index = 0.
- Handshake to start: accept at edge n; `conv_start_o` is high during cycle n+1.
- Result to display: `conv_dv_i` at edge m; display register updated at m+1; visible at the next tick after m+1.
- First tick occurs `SCAN_DIV` cycles after reset release. Period per slot = `SCAN_DIV` cycles exactly; full frame = 4·`SCAN_DIV`.
- A `conv_dv_i` on the same edge as the timeout terminal count counts as success: latch the result, no error.
- Back-to-back: re-accept is possible on the cycle after the return to IDLE (minimum 3 cycles per value).
- `RST_N` asserted mid-conversion: immediate return to reset values. A late `conv_dv_i` after reset is ignored.

## Configuration
- `SEG_LZ_BLANK_EN` defined (leading-zero blanking):
  - Slots 3..1 are blanked (enable_n forced to 4'b1111 for that slot) while their nibble and all higher nibbles are 0.
  - Slot 0 is never blanked. Example: 0042 shows "42"; 0 shows "0".
- Undefined: all four slots are always enabled and leading zeros are shown.

## Structure
- Package `seg_pkg`:
  - FSM state enum.
  - `NUM_DIGITS`=4, `BCD_W`=16, `VAL_W`=14, `MAX_VAL`=9999.
  - The four enable-pattern constants.
- Sub-module `scan_timer`: prescaler plus 2-bit slot index; outputs `tick` and `slot`.
- Top-level: FSM, timeout counter, display register, slot mux, blanking logic.

## Test plan
- Reset check: reset, then hold for 3·`SCAN_DIV` with no input → all enables 4'b1111 until the first tick, then slots cycle 0111/1011/1101/1110 with `digit_o`=0; ready=1.
- Nominal conversion: offer 1234 with a converter model answering dv after 20 cycles → one start pulse, `conv_value_o`=1234. After the next frame the slots show 4,3,2,1 on enables 0111..1110.
- Overflow clamp: offer 12000 → `conv_value_o`=9999, `overflow_o`=1. Then offer 5 → `overflow_o`=0.
- Timeout: converter never asserts dv → `conv_error_o`=1 exactly `CONV_TIMEOUT` cycles after start; display keeps its prior value; ready returns.
- Timeout collision: dv on the terminal timeout cycle → result latched, `conv_error_o`=0. A spurious dv while in IDLE → display unchanged.
- Blanking (`SEG_LZ_BLANK_EN`): value 42 → slots 3 and 2 dark, slots 1 and 0 show 4 and 2. Value 0 → only slot 0 lit, showing 0. Without the macro → all four slots lit.
